// File: rtl/bfloat_mantissa_div_if.sv
// Valid/ready operand and result channels of the bfloat16 significand divider.
// The sticky signal exists only when BFLOAT_DIV_STICKY_EN is defined.
interface bfloat_mantissa_div_if #(
  parameter int unsigned FRAC_W = 7
);
  localparam int unsigned QUOT_W = FRAC_W + 2;

  logic              in_valid;
  logic              in_ready;
  logic [FRAC_W-1:0] a;
  logic [FRAC_W-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [QUOT_W-1:0] q;
`ifdef BFLOAT_DIV_STICKY_EN
  logic              sticky;
`endif

  // Upstream/downstream side: drives operands, consumes results
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q
`ifdef BFLOAT_DIV_STICKY_EN
    , input sticky
`endif
  );

  // Divider side
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q
`ifdef BFLOAT_DIV_STICKY_EN
    , output sticky
`endif
  );
endinterface

// File: rtl/bfloat_mantissa_div.sv
// Iterative restoring divider for bfloat16 significands, one quotient bit per cycle.
// q = floor(({1,a} << (FRAC_W+1)) / {1,b}); q MSB is the integer bit.
// Optional feature macro: BFLOAT_DIV_STICKY_EN adds the remainder-nonzero sticky output.
module bfloat_mantissa_div #(
  parameter int unsigned FRAC_W = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bfloat_mantissa_div_if.slave   bus
);
  localparam int unsigned QUOT_W = FRAC_W + 2;
  localparam int unsigned SIG_W  = FRAC_W + 1;
  localparam int unsigned REM_W  = FRAC_W + 2;
  localparam int unsigned CNT_W  = $clog2(QUOT_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [REM_W-1:0]   r_rem;
  logic [SIG_W-1:0]   r_div;
  logic [QUOT_W-1:0]  r_q;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               w_accept;
  logic               w_last;
  logic               w_ge;
  logic [REM_W-1:0]   w_diff;
  logic [REM_W-1:0]   w_rem_nxt;

  assign w_accept = bus.in_valid && (r_state == ST_IDLE);
  assign w_last   = (r_cnt == CNT_W'(QUOT_W - 1));

  // Restoring step: R < B on entry keeps the shifted value inside REM_W bits
  assign w_ge      = (r_rem >= REM_W'(r_div));
  assign w_diff    = r_rem - REM_W'(r_div);
  assign w_rem_nxt = w_ge ? {w_diff[REM_W-2:0], 1'b0} : {r_rem[REM_W-2:0], 1'b0};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)      w_state_nxt = ST_CALC;
      ST_CALC: if (w_last)        w_state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered handshake outputs track the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
    end
  end

  // Operand capture and one quotient bit per CALC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_div <= '0;
      r_q   <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rem <= REM_W'({1'b1, bus.a});
            r_div <= {1'b1, bus.b};
            r_q   <= '0;
            r_cnt <= '0;
          end
        end
        ST_CALC: begin
          r_rem <= w_rem_nxt;
          r_q   <= {r_q[QUOT_W-2:0], w_ge};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef BFLOAT_DIV_STICKY_EN
  logic r_sticky;

  // Sticky captures a nonzero final remainder; cleared when a new op is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_accept) begin
      r_sticky <= 1'b0;
    end else if ((r_state == ST_CALC) && w_last) begin
      r_sticky <= (w_rem_nxt != '0);
    end
  end

  assign bus.sticky = r_sticky;
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.q         = r_q;
endmodule

// File: tb/tb_bfloat_mantissa_div.sv
// Directed self-checking bench for bfloat_mantissa_div.
// Sticky checks are active when BFLOAT_DIV_STICKY_EN is defined.
module tb_bfloat_mantissa_div;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bfloat_mantissa_div_if #(.FRAC_W(7)) bus();

  bfloat_mantissa_div #(.FRAC_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Issue one operation from IDLE and wait (bounded) for out_valid; out_ready left as is
  task automatic run_op(input logic [6:0] a, input logic [6:0] b,
                        output logic [8:0] q, output logic st, output int lat);
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 7'h55;
    bus.b        = 7'h2A;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    q = bus.q;
`ifdef BFLOAT_DIV_STICKY_EN
    st = bus.sticky;
`else
    st = 1'b0;
`endif
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++;
    if (bus.q !== 9'h000) begin n_fail++; $display("FAIL reset_q got=%h exp=000", bus.q); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
`ifdef BFLOAT_DIV_STICKY_EN
    n_checks++;
    if (bus.sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky got=%b exp=0", bus.sticky); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_basic();
    logic [6:0] va [3] = '{7'h00, 7'h40, 7'h00};
    logic [6:0] vb [3] = '{7'h00, 7'h00, 7'h7F};
    logic [8:0] eq [3] = '{9'h100, 9'h180, 9'h080};
    logic       es [3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] q;
    logic       st;
    int         lat;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], q, st, lat);
      n_checks++;
      if (q !== eq[i]) begin n_fail++; $display("FAIL basic_q[%0d] got=%h exp=%h", i, q, eq[i]); end
      n_checks++;
      if (lat != 9) begin n_fail++; $display("FAIL basic_latency[%0d] got=%0d exp=9", i, lat); end
`ifdef BFLOAT_DIV_STICKY_EN
      n_checks++;
      if (st !== es[i]) begin n_fail++; $display("FAIL basic_sticky[%0d] got=%b exp=%b", i, st, es[i]); end
`else
      if (st !== 1'b0 && es[i] === 1'bx) $display("note: unreachable");
`endif
      consume();
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_consume[%0d] got out_valid=%b in_ready=%b exp out_valid=0 in_ready=1",
                 i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_hold();
    logic [8:0] q;
    logic       st;
    int         lat;
    run_op(7'h00, 7'h40, q, st, lat);
    n_checks++;
    if (q !== 9'h0AA) begin n_fail++; $display("FAIL hold_q got=%h exp=0aa", q); end
`ifdef BFLOAT_DIV_STICKY_EN
    n_checks++;
    if (st !== 1'b1) begin n_fail++; $display("FAIL hold_sticky got=%b exp=1", st); end
`endif
    // New operands offered while DONE must be ignored
    bus.a        = 7'h7F;
    bus.b        = 7'h00;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.q !== 9'h0AA || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable[%0d] got q=%h out_valid=%b in_ready=%b exp q=0aa out_valid=1 in_ready=0",
                 i, bus.q, bus.out_valid, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    consume();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_consume got out_valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready);
    end
    // Nothing was accepted during DONE, so no further result appears
    repeat (12) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_no_extra_op got out_valid=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] va [4] = '{7'h15, 7'h7F, 7'h33, 7'h01};
    logic [6:0] vb [4] = '{7'h6A, 7'h00, 7'h33, 7'h7E};
    logic [8:0] eq [4];
    int issued = 0;
    int got    = 0;
    int cyc    = 0;
    int last   = -1;
    for (int i = 0; i < 4; i++)
      eq[i] = 9'((((32'd128 + 32'(va[i])) << 8)) / (32'd128 + 32'(vb[i])));
    bus.out_ready = 1'b1;
    while (got < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) begin
        n_checks++;
        if (bus.q !== eq[got]) begin n_fail++; $display("FAIL b2b_q[%0d] got=%h exp=%h", got, bus.q, eq[got]); end
        if (last >= 0) begin
          n_checks++;
          if (cyc - last != 11) begin n_fail++; $display("FAIL b2b_spacing[%0d] got=%0d exp=11", got, cyc - last); end
        end
        last = cyc;
        got++;
        bus.in_valid = (issued < 4);
      end
      if (bus.in_ready) begin
        if (issued < 4) begin
          bus.a        = va[issued];
          bus.b        = vb[issued];
          bus.in_valid = 1'b1;
          issued++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (got != 4) begin n_fail++; $display("FAIL b2b_timeout got=%0d results exp=4", got); end
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [8:0] q;
    logic       st;
    int         lat;
    logic       seen = 1'b0;
    @(negedge clk);
    bus.a        = 7'h40;
    bus.b        = 7'h00;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.q !== 9'h000) begin
      n_fail++;
      $display("FAIL midreset_clear got out_valid=%b q=%h exp 0/000", bus.out_valid, bus.q);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready got=%b exp=1", bus.in_ready); end
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_no_pulse got=%b exp=0", seen); end
    run_op(7'h7F, 7'h7F, q, st, lat);
    n_checks++;
    if (q !== 9'h100) begin n_fail++; $display("FAIL midreset_next_q got=%h exp=100", q); end
`ifdef BFLOAT_DIV_STICKY_EN
    n_checks++;
    if (st !== 1'b0) begin n_fail++; $display("FAIL midreset_next_sticky got=%b exp=0", st); end
`endif
    consume();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
